tdm_demux4: RTL and testbench

- Serial-to-parallel time-division demultiplexer.
- It is the receive end of the 4:1 mux path. In that path the mux's select steps slots 0..N-1 and places one input per slot on a serial line.
- This block rebuilds the parallel word from that line and presents the whole frame at once with a one-cycle valid pulse.
- It sits downstream of the mux/serial link, ahead of any consumer of the parallel word.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_parity_acc.sv | 46 ++++
 rtl/tdm_demux4.sv | 165 ++++++++++++++++
 tb/tb_tdm_demux4.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM mux/demux path.
//   tdm_state_e : receive-side frame state (IDLE, COLLECT, PARITY)
//   TDM_NCH     : default number of slots per frame
//   TDM_W       : default width of one slot in bits
// ---------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } tdm_state_e;

    localparam int TDM_NCH = 4;
    localparam int TDM_W   = 1;

endpackage : tdm_pkg

// File: rtl/tdm_parity_acc.sv
// ---------------------------------------------------------------------------
// tdm_parity_acc
// Running even-parity (XOR) accumulator over the data beats of one frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : slot-0 beat; restart the accumulation with this beat's data
//   en         : later data beat; fold its bits into the running XOR
//   din        : slot data (W bits)
//   parity     : XOR of every data bit accepted since the last clear
// Only instantiated when TDM_DEMUX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tdm_parity_acc
    import tdm_pkg::*;
#(
    parameter int W = TDM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic         parity
);

    logic acc_d, acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = ^din;
        end else if (en) begin
            acc_d = acc_q ^ (^din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign parity = acc_q;

endmodule : tdm_parity_acc

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
// Serial-to-parallel TDM demultiplexer: rebuilds an NCH-slot frame from the
// serial line and presents it on dout with a one-cycle dout_valid pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   din_valid    : din/frame_start valid this cycle
//   frame_start  : beat carries slot 0
//   din          : serial slot data (W bits)
//   dout         : assembled frame, slot k at dout[k*W +: W]
//   dout_valid   : one-cycle pulse, new frame on dout
//   slot_idx     : slot the next accepted data beat will fill
//   busy         : frame partially collected
//   frame_err    : one-cycle pulse, frame aborted by an early frame_start
//   parity_err   : one-cycle pulse, parity beat mismatch
// Build option: define TDM_DEMUX_PARITY_EN to expect a trailing even-parity
// beat after slot NCH-1; otherwise parity_err is tied to 0.
// ---------------------------------------------------------------------------
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int NCH = TDM_NCH,
    parameter int W   = TDM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    din_valid,
    input  logic                    frame_start,
    input  logic [W-1:0]            din,
    output logic [NCH*W-1:0]        dout,
    output logic                    dout_valid,
    output logic [$clog2(NCH)-1:0]  slot_idx,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    parity_err
);

    localparam int            SW   = $clog2(NCH);
    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    tdm_state_e          state_d, state_q;
    logic [SW-1:0]       slot_idx_d, slot_idx_q;
    logic [NCH*W-1:0]    asm_d, asm_q;
    logic [NCH*W-1:0]    dout_d, dout_q;
    logic                dout_valid_d, dout_valid_q;
    logic                frame_err_d, frame_err_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic parity_err_d, parity_err_q;
    logic acc_clear, acc_en, acc_parity;

    tdm_parity_acc #(.W(W)) u_parity_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .en     (acc_en),
        .din    (din),
        .parity (acc_parity)
    );
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d      = state_q;
        slot_idx_d   = slot_idx_q;
        asm_d        = asm_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
        acc_clear    = 1'b0;
        acc_en       = 1'b0;
`endif

        if (din_valid && frame_start) begin
            // A slot-0 beat always starts a fresh frame; outside IDLE it
            // aborts the partial frame, which never reaches dout.
            frame_err_d    = (state_q != IDLE);
            asm_d          = '0;
            asm_d[W-1:0]   = din;
            slot_idx_d     = SW'(1);
            state_d        = COLLECT;
`ifdef TDM_DEMUX_PARITY_EN
            acc_clear      = 1'b1;
`endif
        end else if (din_valid) begin
            case (state_q)
                COLLECT: begin
                    asm_d[int'(slot_idx_q)*W +: W] = din;
`ifdef TDM_DEMUX_PARITY_EN
                    acc_en = 1'b1;
`endif
                    if (slot_idx_q == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                        // slot_idx parks on LAST until the parity beat.
                        state_d = PARITY;
`else
                        dout_d       = asm_d;
                        dout_valid_d = 1'b1;
                        slot_idx_d   = '0;
                        state_d      = IDLE;
`endif
                    end else begin
                        slot_idx_d = slot_idx_q + SW'(1);
                    end
                end
`ifdef TDM_DEMUX_PARITY_EN
                PARITY: begin
                    if (din[0] == acc_parity) begin
                        dout_d       = asm_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                    slot_idx_d = '0;
                    state_d    = IDLE;
                end
`endif
                default: ;  // IDLE: beats without frame_start are dropped
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_idx_q   <= '0;
            // NOTE: the assembly register is a plain flop bank, not a RAM, so
            // it takes the async reset like every other state element.
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so all flops sample the pre-edge
            // values computed above, independent of statement order.
            state_q      <= state_d;
            slot_idx_q   <= slot_idx_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot_idx   = slot_idx_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4
// Self-checking bench for tdm_demux4 (NCH=4, W=1). Inputs change on the
// falling edge, outputs are sampled on the following falling edge. Expected
// frames are queued when their last beat is driven and popped by a monitor
// whenever dout_valid is seen.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid;
    logic       frame_start;
    logic [0:0] din;
    logic [3:0] dout;
    logic       dout_valid;
    logic [1:0] slot_idx;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    logic [3:0] sb[$];

    tdm_demux4 #(.NCH(4), .W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .slot_idx    (slot_idx),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat at a falling edge and return at the next falling edge,
    // where the outputs reflect that beat.
    task automatic step(input logic v, input logic fs, input logic d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every dout_valid pulse must match the oldest
    // queued frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("sb_dout", {28'd0, dout}, {28'd0, sb.pop_front()});
            end
        end
    end

    // seq[0] is the first beat in time (slot 0). hold is the dout value that
    // must persist until completion; exp_fe is frame_err after the first beat.
    task automatic send_frame(input logic [0:3] seq, input logic [3:0] exp,
                              input logic [3:0] hold, input int gap,
                              input logic exp_fe);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
`ifndef TDM_DEMUX_PARITY_EN
                sb.push_back(exp);
`endif
            end
            step(1'b1, k == 0, seq[k]);
            if (k == 0) check("first_fe", {31'd0, frame_err}, {31'd0, exp_fe});
            if (k < 3) begin
                check("mid_busy", {31'd0, busy}, 32'd1);
                check("mid_slot", {30'd0, slot_idx}, k + 1);
                check("mid_dv", {31'd0, dout_valid}, 32'd0);
                check("mid_dout", {28'd0, dout}, {28'd0, hold});
            end
            if (k == 1) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 1'b1);
                    check("gap_busy", {31'd0, busy}, 32'd1);
                    check("gap_dv", {31'd0, dout_valid}, 32'd0);
                    check("gap_slot", {30'd0, slot_idx}, 32'd2);
                end
            end
        end
`ifdef TDM_DEMUX_PARITY_EN
        check("pre_par_dv", {31'd0, dout_valid}, 32'd0);
        check("pre_par_busy", {31'd0, busy}, 32'd1);
        sb.push_back(exp);
        step(1'b1, 1'b0, ^seq);
        check("par_ok_err", {31'd0, parity_err}, 32'd0);
`endif
        check("done_dv", {31'd0, dout_valid}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_slot", {30'd0, slot_idx}, 32'd0);
    endtask

    typedef struct {
        logic [0:3] seq;   // beats in time order
        logic [3:0] exp;   // dout, slot k at bit k
    } vec_t;

    vec_t vecs[6];
    logic [3:0] cur;

    initial begin
        vecs[0] = '{seq: 4'b1011, exp: 4'b1101};
        vecs[1] = '{seq: 4'b0110, exp: 4'b0110};
        vecs[2] = '{seq: 4'b0010, exp: 4'b0100};
        vecs[3] = '{seq: 4'b1111, exp: 4'b1111};
        vecs[4] = '{seq: 4'b1000, exp: 4'b0001};
        vecs[5] = '{seq: 4'b0000, exp: 4'b0000};

        rst_n = 1'b0; din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout", {28'd0, dout}, 32'd0);
        check("rst_dv", {31'd0, dout_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_slot", {30'd0, slot_idx}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_pe", {31'd0, parity_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Beats without frame_start in IDLE are ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check("ign_busy", {31'd0, busy}, 32'd0);
            check("ign_dv", {31'd0, dout_valid}, 32'd0);
            check("ign_fe", {31'd0, frame_err}, 32'd0);
            check("ign_dout", {28'd0, dout}, 32'd0);
        end

        // Basic frame, then one idle cycle: the valid pulse must drop.
        send_frame(4'b1011, 4'b1101, 4'b0000, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("basic_dv_drop", {31'd0, dout_valid}, 32'd0);
        check("basic_dout_hold", {28'd0, dout}, 32'hD);
        cur = 4'b1101;

        // Table frames sent back to back (no dead cycle between them).
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].seq, vecs[i].exp, cur, 0, 1'b0);
            cur = vecs[i].exp;
        end
        step(1'b0, 1'b0, 1'b0);

        // Three-cycle gap between slot 1 and slot 2.
        send_frame(4'b1011, 4'b1101, cur, 3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        cur = 4'b1101;

        // Abort: partial 0,1 frame restarted by a new frame_start.
        step(1'b1, 1'b1, 1'b0);
        check("ab_fe0", {31'd0, frame_err}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("ab_dout0", {28'd0, dout}, 32'hD);
        send_frame(4'b0110, 4'b0110, 4'b1101, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("ab_fe_drop", {31'd0, frame_err}, 32'd0);
        cur = 4'b0110;

        // Reset mid-frame clears outputs asynchronously.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_dout", {28'd0, dout}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_slot", {30'd0, slot_idx}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(4'b0010, 4'b0100, 4'b0000, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        cur = 4'b0100;

`ifdef TDM_DEMUX_PARITY_EN
        // Good parity after 1011, then the same frame with wrong parity.
        send_frame(4'b1011, 4'b1101, cur, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        cur = 4'b1101;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("pe_pulse", {31'd0, parity_err}, 32'd1);
        check("pe_dv", {31'd0, dout_valid}, 32'd0);
        check("pe_dout", {28'd0, dout}, 32'hD);
        check("pe_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("pe_drop", {31'd0, parity_err}, 32'd0);
        // frame_start while waiting for parity aborts the frame.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        send_frame(4'b1000, 4'b0001, cur, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tdm_demux4
